// File: rtl/image_write.sv
// image_write: turns an incoming pixel stream into linear image_mem writes from a configured start address
module image_write #(
  parameter int CFG_DWIDTH  = 32,
  parameter int CFG_AWIDTH  = 5,
  parameter int GROUP_NB    = 4,
  parameter int IMG_WIDTH   = 16,
  parameter int MEM_AWIDTH  = 16,
  parameter int CFG_IW_ADDR = 0,
  parameter int CFG_IW_LEN  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CFG_DWIDTH-1:0]         cfg_data,
  input  logic [CFG_AWIDTH-1:0]         cfg_addr,
  input  logic                          cfg_valid,
  input  logic                          next,
  input  logic [GROUP_NB*IMG_WIDTH-1:0] str_bus,
  input  logic                          str_last,
  input  logic                          str_val,
  output logic                          str_rdy,
  output logic                          wr_val,
  output logic [MEM_AWIDTH-1:0]         wr_addr,
  output logic [GROUP_NB*IMG_WIDTH-1:0] wr_data,
  output logic                          done,
  output logic                          err_last
);
  typedef enum logic [2:0] {S_RESET = 3'b001, S_CONFIG = 3'b010, S_ACTIVE = 3'b100} state_t;
  state_t state, state_nx;
  logic [MEM_AWIDTH-1:0] sh_addr, addr_cnt;
  logic [CFG_DWIDTH-1:0] sh_len, len_max, beat_cnt;
  logic accept, at_len, term, arm;
  assign str_rdy = state == S_ACTIVE;
  assign accept  = str_val & str_rdy;
  assign at_len  = beat_cnt == len_max;
  assign term    = accept & (at_len | str_last);
  assign arm     = next & (state == S_CONFIG);
  // shadow cfg registers, only copied into the working set when a transfer is armed
  always_ff @(posedge clk) begin
    if (cfg_valid && cfg_addr == CFG_IW_ADDR[CFG_AWIDTH-1:0]) sh_addr <= cfg_data[MEM_AWIDTH-1:0];
    if (cfg_valid && cfg_addr == CFG_IW_LEN[CFG_AWIDTH-1:0]) sh_len <= cfg_data;
  end
  // state register
  always_ff @(posedge clk) state <= rst ? S_RESET : state_nx;
  // next state: RESET always falls through to CONFIG, arm starts, terminating beat ends
  always_comb state_nx = state == S_RESET ? S_CONFIG : arm ? S_ACTIVE : term ? S_RESET : state;
  // working address/beat counters; address wraps at the memory width
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_cnt <= '0;
      len_max  <= '0;
      beat_cnt <= '0;
    end else if (arm) begin
      addr_cnt <= sh_addr;
      len_max  <= sh_len;
      beat_cnt <= '0;
    end else if (accept) begin
      addr_cnt <= addr_cnt + 1'b1;
      beat_cnt <= beat_cnt + 1'b1;
    end
  end
  // one register stage on the write port; address/data forced to zero when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_val   <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      done     <= 1'b0;
      err_last <= 1'b0;
    end else begin
      wr_val   <= accept;
      wr_addr  <= accept ? addr_cnt : '0;
      wr_data  <= accept ? str_bus : '0;
      done     <= term;
      err_last <= term & (str_last ? beat_cnt < len_max : at_len);
    end
  end
endmodule

// File: doc/image_write.md
# image_write

Generates write requests into `image_mem` from an incoming pixel stream (DMA/host side), laying each image segment down linearly from a configured start address. It is the producer for the segment that `image_read` later walks with conv/maxpool addressing; the stream arrives depth-fastest, then width, then height, so sequential addressing gives the H×W×D layout the read side expects. Configuration uses the shared cfg bus, and a `next` pulse arms one transfer.

## Interface
- `CFG_DWIDTH`, 32, cfg bus data width
- `CFG_AWIDTH`, 5, cfg bus address width
- `GROUP_NB`, 4, pixels per memory word
- `IMG_WIDTH`, 16, bits per pixel
- `MEM_AWIDTH`, 16, image_mem address width

- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  reset, synchronous and active-high
- `cfg_data`  in  CFG_DWIDTH  cfg value
- `cfg_addr`  in  CFG_AWIDTH  cfg register select; uses `CFG_IW_ADDR`, `CFG_IW_LEN` from `cfg_parameters.vh`
- `cfg_valid`  in  1  cfg write strobe
- `next`  in  1  latch cfg shadow values and arm a transfer
- `str_bus`  in  GROUP_NB*IMG_WIDTH  incoming word
- `str_last`  in  1  final word of segment, per the sender
- `str_val`  in  1  word valid
- `str_rdy`  out  1  block accepts a word
- `wr_val`  out  1  memory write strobe
- `wr_addr`  out  MEM_AWIDTH  memory write address
- `wr_data`  out  GROUP_NB*IMG_WIDTH  memory write data
- `done`  out  1  one-cycle pulse with the final write
- `err_last`  out  1  one-cycle pulse, `str_last` disagreed with configured length

## Operation
- Cfg registers (shadow, no reset): `CFG_IW_ADDR` → start address (`cfg_data[MEM_AWIDTH-1:0]`); `CFG_IW_LEN` → length, zero-indexed (0 = 1 word), 32 bits. Cfg writes at any time only change shadows.
- One-hot FSM: RESET → CONFIG (unconditional, 1 cycle) → ACTIVE (on `next` in CONFIG) → RESET (on terminating beat). `rst` forces RESET.
- `next` in CONFIG copies shadows into working `addr_cnt` (start) and `len_max`, clears `beat_cnt`. `next` in RESET or ACTIVE is ignored.
- `str_rdy` = state is ACTIVE (decoded from state register, no combinational path from `str_val`).
- Beat accepted when `str_val & str_rdy`: `addr_cnt` += 1, `beat_cnt` += 1.
- Address arithmetic is MEM_AWIDTH-wide; `addr_cnt` wraps from 2^MEM_AWIDTH−1 to 0 silently.
- Terminating beat: accepted beat with `beat_cnt == len_max` OR `str_last` high. The beat is always written; FSM then goes to RESET.
- `err_last` pulses with the terminating write when (`str_last` high and `beat_cnt < len_max`) — early end — or (`str_last` low and `beat_cnt == len_max`) — missing last.
- `done` pulses with the terminating write in both the normal and error cases.

## Timing
- Reset values: `str_rdy`=0, `wr_val`=0, `wr_addr`=0, `wr_data`=0, `done`=0, `err_last`=0; FSM enters RESET, then CONFIG the next cycle.
- `next` high at edge N (in CONFIG) → ACTIVE from N+1, `str_rdy` high in cycle N+1.
- Beat accepted at edge K → `wr_val`=1, `wr_addr`, `wr_data` valid in cycle K+1 (one register stage). `wr_addr`/`wr_data` are 0 whenever `wr_val` is 0.
- Terminating beat at edge K: `str_rdy` low from cycle K+1; `done`/`err_last` with `wr_val` in K+1; back in CONFIG at K+2, so earliest re-arm `next` is at edge K+2.
- Full-rate: back-to-back `str_val` gives one write per cycle, no bubbles.
- `str_val` low in ACTIVE: no state change, no write.
- `rst` mid-transfer: next cycle all outputs at reset values, pending beat dropped, no `done`.

## Test plan
- Start 0x0100, len cfg 7, 8 contiguous beats with `str_last` on 8th → writes 0x0100..0x0107, data in order, `done` with 0x0107 write, `err_last`=0, `str_rdy` low after.
- Same cfg, `str_val` toggled every other cycle → same 8 writes, each 1 cycle after acceptance, no extra writes.
- Start 0xFFFE, len cfg 3 → addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001; `done` on 0x0001.
- Len cfg 7, `str_last` on 5th beat → 5 writes, `done` and `err_last` on 5th; len cfg 3 with no `str_last` → 4 writes, `done`+`err_last` on 4th.
- Cfg rewritten during ACTIVE, then `next` during ACTIVE → current transfer unaffected, no restart; following `next` in CONFIG uses new values.
- `rst` asserted after 3 of 8 beats → 3 writes only, `done`=0, `str_rdy` 0; new `next` starts cleanly from configured start.
